// File: rtl/jk_bank_ctrl_if.sv
// Command/readback bundle between a host, jk_bank_ctrl and the external JK flip-flop bank.
`timescale 1ns/1ps
interface jk_bank_ctrl_if #(
    parameter int unsigned N = 4
);
    logic         cmd_valid;
    logic [2:0]   cmd_op;
    logic [N-1:0] cmd_data;
    logic         cmd_ready;
    logic [N-1:0] q_in;
    logic [N-1:0] j_out;
    logic [N-1:0] k_out;
    logic         busy;
    logic         done;
    logic         err;
    logic         wrap;

    modport master (
        output cmd_valid, cmd_op, cmd_data, q_in,
        input  cmd_ready, j_out, k_out, busy, done, err, wrap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, q_in,
        output cmd_ready, j_out, k_out, busy, done, err, wrap
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Sequences J/K drive of an external N-bit JK flip-flop bank (clear/set/load/toggle/count).
// Optional readback compare of the bank q against the expected value: JK_READBACK_CHECK_EN.
`timescale 1ns/1ps
module jk_bank_ctrl #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    jk_bank_ctrl_if.slave  bus
);
    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_COUNT  = 3'd5;

    typedef enum logic [2:0] {IDLE, APPLY, CHECK, CNT_DRV, CNT_WAIT, FIN} state_t;

    state_t           state_q, state_nx;
    logic [N-1:0]     j_q, j_nx, k_q, k_nx;
    logic [N-1:0]     exp_q, exp_nx;
    logic [CNT_W-1:0] rem_q, rem_nx;
    logic             wrap_acc_q, wrap_acc_nx;
    logic             ill_q, ill_nx;
    logic             done_q, done_nx, err_q, err_nx, wrap_q, wrap_nx;
    logic             busy_q, ready_q;
    logic             mismatch_c;
    logic [N-1:0]     q_inc_c, exp_inc_c, cnt_jk_c;
    logic [CNT_W-1:0] steps_c;

    // Synchronous-counter drive: bit i toggles when all lower bits are 1.
    function automatic logic [N-1:0] count_drive(input logic [N-1:0] q);
        logic [N-1:0] r;
        logic         carry;
        carry = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            r[i]  = carry;
            carry = carry & q[i];
        end
        return r;
    endfunction

    assign q_inc_c   = bus.q_in + N'(1);
    assign exp_inc_c = exp_q + N'(1);
    assign cnt_jk_c  = count_drive(bus.q_in);
    assign steps_c   = CNT_W'(bus.cmd_data);

`ifdef JK_READBACK_CHECK_EN
    assign mismatch_c = (bus.q_in != exp_q);
`else
    assign mismatch_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            j_q        <= '0;
            k_q        <= '0;
            exp_q      <= '0;
            rem_q      <= '0;
            wrap_acc_q <= 1'b0;
            ill_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_nx;
            j_q        <= j_nx;
            k_q        <= k_nx;
            exp_q      <= exp_nx;
            rem_q      <= rem_nx;
            wrap_acc_q <= wrap_acc_nx;
            ill_q      <= ill_nx;
            done_q     <= done_nx;
            err_q      <= err_nx;
            wrap_q     <= wrap_nx;
            busy_q     <= (state_nx != IDLE);
            ready_q    <= (state_nx == IDLE);
        end
    end

    // Next state plus next values of every registered output; J/K idle at zero by default.
    always_comb begin
        state_nx    = state_q;
        j_nx        = '0;
        k_nx        = '0;
        exp_nx      = exp_q;
        rem_nx      = rem_q;
        wrap_acc_nx = wrap_acc_q;
        ill_nx      = ill_q;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        wrap_nx     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    ill_nx      = 1'b0;
                    wrap_acc_nx = 1'b0;
                    case (bus.cmd_op)
                        OP_NOP: state_nx = FIN;
                        OP_CLEAR: begin
                            state_nx = APPLY;
                            k_nx     = '1;
                            exp_nx   = '0;
                        end
                        OP_SET: begin
                            state_nx = APPLY;
                            j_nx     = '1;
                            exp_nx   = '1;
                        end
                        OP_LOAD: begin
                            state_nx = APPLY;
                            j_nx     = bus.cmd_data;
                            k_nx     = ~bus.cmd_data;
                            exp_nx   = bus.cmd_data;
                        end
                        OP_TOGGLE: begin
                            state_nx = APPLY;
                            j_nx     = bus.cmd_data;
                            k_nx     = bus.cmd_data;
                            exp_nx   = bus.q_in ^ bus.cmd_data;
                        end
                        OP_COUNT: begin
                            if (steps_c == '0) begin
                                state_nx = FIN;
                            end else begin
                                state_nx    = CNT_DRV;
                                j_nx        = cnt_jk_c;
                                k_nx        = cnt_jk_c;
                                exp_nx      = q_inc_c;
                                rem_nx      = steps_c;
                                wrap_acc_nx = (q_inc_c == '0);
                            end
                        end
                        default: begin
                            state_nx = FIN;
                            ill_nx   = 1'b1;
                        end
                    endcase
                end
            end
            APPLY: state_nx = CHECK;
            CHECK: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
                err_nx   = mismatch_c;
            end
            CNT_DRV: state_nx = CNT_WAIT;
            CNT_WAIT: begin
                if (rem_q > CNT_W'(1)) begin
                    state_nx    = CNT_DRV;
                    j_nx        = cnt_jk_c;
                    k_nx        = cnt_jk_c;
                    exp_nx      = exp_inc_c;
                    rem_nx      = rem_q - CNT_W'(1);
                    wrap_acc_nx = wrap_acc_q | (exp_inc_c == '0);
                end else begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    err_nx   = mismatch_c;
                    wrap_nx  = wrap_acc_q;
                end
            end
            FIN: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
                err_nx   = ill_q;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.j_out     = j_q;
    assign bus.k_out     = k_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.wrap      = wrap_q;
    assign bus.busy      = busy_q;
    assign bus.cmd_ready = ready_q;
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl driving a behavioural 4-bit JK bank.
`timescale 1ns/1ps
module tb_jk_bank_ctrl;
    logic       clk;
    logic       rst;
    logic [3:0] bank_q = 4'b0000;
    logic [3:0] stuck  = 4'b0000;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct {
        logic       err;
        logic       wrap;
        logic [3:0] q;
        int         lat;
        int         t;
        string      name;
    } exp_t;
    exp_t sbq[$];

    jk_bank_ctrl_if #(.N(4)) bus ();

    jk_bank_ctrl #(.N(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // JK bank: 00 hold, 01 reset, 10 set, 11 toggle; stuck bits read back as 0
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            case ({bus.j_out[i], bus.k_out[i]})
                2'b01:   bank_q[i] <= 1'b0;
                2'b10:   bank_q[i] <= 1'b1;
                2'b11:   bank_q[i] <= ~bank_q[i];
                default: bank_q[i] <= bank_q[i];
            endcase
        end
    end
    assign bus.q_in = bank_q & ~stuck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse pops one expected response
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.done) begin
            if (sbq.size() == 0) begin
                check("unexpected done", 32'(bus.done), 32'd0);
            end else begin
                e = sbq.pop_front();
                check({e.name, " err"},  32'(bus.err),  32'(e.err));
                check({e.name, " wrap"}, 32'(bus.wrap), 32'(e.wrap));
                check({e.name, " q"},    32'(bus.q_in), 32'(e.q));
                check({e.name, " latency"}, 32'(cyc - e.t), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] d, input bit push,
                         input logic e_err, input logic e_wrap, input logic [3:0] e_q,
                         input int e_lat, input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({name, " ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (push) sbq.push_back('{e_err, e_wrap, e_q, e_lat, cyc, name});
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("idle timeout", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_stuck_err;
`ifdef JK_READBACK_CHECK_EN
        exp_stuck_err = 1'b1;
`else
        exp_stuck_err = 1'b0;
`endif
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 4'd0;
        repeat (2) @(negedge clk);
        check("reset j", 32'(bus.j_out), 32'h0);
        check("reset k", 32'(bus.k_out), 32'h0);
        check("reset ready", 32'(bus.cmd_ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        // Reset mid-cycle while SET drives the bank: bank must not change
        issue(3'd2, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 0, "aborted SET");
        check("SET drive j", 32'(bus.j_out), 32'hf);
        #1 rst = 1'b1;
        #1;
        check("midreset j", 32'(bus.j_out), 32'h0);
        check("midreset k", 32'(bus.k_out), 32'h0);
        check("midreset ready", 32'(bus.cmd_ready), 32'd1);
        check("midreset busy", 32'(bus.busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset bank q", 32'(bus.q_in), 32'h0);

        // LOAD 1010
        issue(3'd3, 4'b1010, 1'b1, 1'b0, 1'b0, 4'b1010, 2, "LOAD");
        check("LOAD j", 32'(bus.j_out), 32'ha);
        check("LOAD k", 32'(bus.k_out), 32'h5);
        @(posedge clk); #1;
        check("LOAD j after", 32'(bus.j_out), 32'h0);
        check("LOAD k after", 32'(bus.k_out), 32'h0);
        check("LOAD bank q", 32'(bus.q_in), 32'ha);

        // TOGGLE 0110 with a CLEAR presented while busy (must be dropped)
        issue(3'd4, 4'b0110, 1'b1, 1'b0, 1'b0, 4'b1100, 2, "TOGGLE");
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd1;
        check("busy ready", 32'(bus.cmd_ready), 32'd0);
        check("busy flag", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;

        // COUNT 3 from 1110: 1111, 0000, 0001 with wrap
        issue(3'd3, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b1110, 2, "LOAD2");
        issue(3'd5, 4'd3, 1'b1, 1'b0, 1'b1, 4'b0001, 6, "COUNT3");
        @(posedge clk); #1;
        check("COUNT3 step1 q", 32'(bus.q_in), 32'hf);
        repeat (2) @(posedge clk);
        #1;
        check("COUNT3 step2 q", 32'(bus.q_in), 32'h0);

        issue(3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'b0001, 1, "NOP");
        issue(3'd5, 4'd0, 1'b1, 1'b0, 1'b0, 4'b0001, 1, "COUNT0");
        issue(3'd7, 4'hf, 1'b1, 1'b1, 1'b0, 4'b0001, 1, "ILLEGAL7");
        check("ILLEGAL7 j", 32'(bus.j_out), 32'h0);
        check("ILLEGAL7 k", 32'(bus.k_out), 32'h0);

        // SET with bit 2 reading back stuck at 0
        wait_idle();
        @(negedge clk);
        stuck = 4'b0100;
        issue(3'd2, 4'd0, 1'b1, exp_stuck_err, 1'b0, 4'b1011, 2, "SET stuck");
        wait_idle();
        @(negedge clk);
        stuck = 4'b0000;

        // COUNT 5 from 1111, reset during second CNT_WAIT (bank at 0001)
        issue(3'd5, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 0, "aborted COUNT5");
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("cntreset j", 32'(bus.j_out), 32'h0);
        check("cntreset k", 32'(bus.k_out), 32'h0);
        check("cntreset busy", 32'(bus.busy), 32'd0);
        check("cntreset ready", 32'(bus.cmd_ready), 32'd1);
        check("cntreset done", 32'(bus.done), 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        check("cntreset bank q", 32'(bus.q_in), 32'h1);

        issue(3'd1, 4'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 2, "CLEAR");
        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
